// File: rtl/tt_loop_filter.sv
// Proportional-integral loop filter: PFD up/down pulses -> saturated DCO control code.
// Define TT_LF_LOCK_DET_EN to build in the alternating-event lock detector.
module tt_loop_filter #(
    parameter int CTRL_W    = 8,
    parameter int INIT_CODE = 128,
    parameter int INT_W     = 12,
    parameter int FRAC_BITS = 2,
    parameter int KP_SHIFT  = 2,
    parameter int LOCK_CNT  = 8
) (
    input  logic              i_clk_gen,
    input  logic              i_rst_n,
    input  logic              i_up,
    input  logic              i_down,
    input  logic              i_hold,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_sat_hi,
    output logic              o_sat_lo,
    output logic              o_lock
);
    localparam int SUM_W = CTRL_W + INT_W + 2;
    localparam logic signed [SUM_W-1:0] INIT_S = SUM_W'(INIT_CODE);
    localparam logic signed [SUM_W-1:0] KICK_S = SUM_W'(1 << KP_SHIFT);
    localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'((1 << CTRL_W) - 1);
    localparam logic signed [1:0] ERR_POS  = 2'sb01;
    localparam logic signed [1:0] ERR_NEG  = 2'sb11;
    localparam logic signed [1:0] ERR_ZERO = 2'sb00;

    logic                     r_up_p0, r_down_p0;
    logic signed [1:0]        w_err, r_err_p1, r_err_p2;
    logic signed [INT_W-1:0]  r_integ_p2, w_integ_next;
    logic                     w_integ_en;
    logic signed [SUM_W-1:0]  w_integ_ext, w_kick, w_sum;
    logic [CTRL_W-1:0]        w_ctrl_next, r_ctrl_p3;
    logic                     r_sat_hi_p3, r_sat_lo_p3;

    // Integrator step that clamps at the signed INT_W limits instead of wrapping.
    function automatic logic signed [INT_W-1:0] sat_integ(input logic signed [INT_W-1:0] a,
                                                          input logic signed [1:0] e);
        logic signed [INT_W:0] t;
        t = {a[INT_W-1], a} + {{(INT_W-1){e[1]}}, e};
        if (t[INT_W] != t[INT_W-1])
            return t[INT_W] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
        return t[INT_W-1:0];
    endfunction

    function automatic logic [CTRL_W-1:0] sat_ctrl(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1]) return '0;
        if (s > MAX_S)  return '1;
        return s[CTRL_W-1:0];
    endfunction

    always_comb begin
        w_err = ERR_ZERO;
        if (r_up_p0 && !r_down_p0)
            w_err = ERR_POS;
        else if (r_down_p0 && !r_up_p0)
            w_err = ERR_NEG;
    end

    // Anti-windup: do not push further into a rail the output is already pinned at.
    always_comb begin
        w_integ_en   = !i_hold
                     && !((r_err_p1 == ERR_POS) && r_sat_hi_p3)
                     && !((r_err_p1 == ERR_NEG) && r_sat_lo_p3);
        w_integ_next = w_integ_en ? sat_integ(r_integ_p2, r_err_p1) : r_integ_p2;
    end

    always_comb begin
        w_integ_ext = {{(SUM_W-INT_W){r_integ_p2[INT_W-1]}}, r_integ_p2};
        w_kick      = '0;
        if (r_err_p2 == ERR_POS)
            w_kick = KICK_S;
        else if (r_err_p2 == ERR_NEG)
            w_kick = -KICK_S;
        w_sum       = INIT_S + (w_integ_ext >>> FRAC_BITS) + w_kick;
        w_ctrl_next = sat_ctrl(w_sum);
    end

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_up_p0     <= 1'b0;
            r_down_p0   <= 1'b0;
            r_err_p1    <= ERR_ZERO;
            r_integ_p2  <= '0;
            r_err_p2    <= ERR_ZERO;
            r_ctrl_p3   <= CTRL_W'(INIT_CODE);
            r_sat_hi_p3 <= 1'b0;
            r_sat_lo_p3 <= 1'b0;
        end else begin
            // p0: capture PFD pulses
            r_up_p0     <= i_up;
            r_down_p0   <= i_down;
            // p1: decoded error
            r_err_p1    <= w_err;
            // p2: integrator and delayed proportional term
            r_integ_p2  <= w_integ_next;
            r_err_p2    <= i_hold ? ERR_ZERO : r_err_p1;
            // p3: clamped output code and rail flags
            r_ctrl_p3   <= w_ctrl_next;
            r_sat_hi_p3 <= (w_ctrl_next == {CTRL_W{1'b1}});
            r_sat_lo_p3 <= (w_ctrl_next == '0);
        end
    end

    assign o_ctrl   = r_ctrl_p3;
    assign o_sat_hi = r_sat_hi_p3;
    assign o_sat_lo = r_sat_lo_p3;

`ifdef TT_LF_LOCK_DET_EN
    localparam int CNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CNT);

    logic [CNT_W-1:0] r_lock_cnt, w_cnt_next;
    logic             r_last_vld, r_last_up, r_lock;
    logic             w_lock_evt, w_evt_up, w_rail;

    // The first event after reset has no predecessor and counts as alternating.
    always_comb begin
        w_rail     = r_sat_hi_p3 || r_sat_lo_p3;
        w_lock_evt = !i_hold && (r_err_p1 != ERR_ZERO);
        w_evt_up   = (r_err_p1 == ERR_POS);
        w_cnt_next = r_lock_cnt;
        if (w_rail)
            w_cnt_next = '0;
        else if (w_lock_evt) begin
            if (r_last_vld && (r_last_up == w_evt_up))
                w_cnt_next = '0;
            else if (r_lock_cnt < LOCK_MAX)
                w_cnt_next = r_lock_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lock_cnt <= '0;
            r_last_vld <= 1'b0;
            r_last_up  <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_lock_cnt <= w_cnt_next;
            if (w_lock_evt) begin
                r_last_vld <= 1'b1;
                r_last_up  <= w_evt_up;
            end
            r_lock <= !w_rail && (w_cnt_next >= LOCK_MAX);
        end
    end

    assign o_lock = r_lock;
`else
    assign o_lock = (LOCK_CNT < 0);  // constant 0; keeps the parameter referenced
`endif
endmodule

// File: doc/tt_loop_filter.md
# tt_loop_filter

Digital proportional-integral loop filter for the all-digital PLL. Consumes the single-cycle `up`/`down` pulses produced by the phase frequency detector and turns them into a saturated, registered oscillator control code. It sits directly downstream of the PFD and drives the DCO tuning input. An optional lock detector flags when the loop is dithering around its operating point.

## Interface
Parameters:
- CTRL_W, 8: width of the unsigned control code `o_ctrl`.
- INIT_CODE, 128: control code after reset; integrator is zero at this point.
- INT_W, 12: width of the signed integrator.
- FRAC_BITS, 2: fractional bits in the integrator. Integral contribution is `integ >>> FRAC_BITS`.
- KP_SHIFT, 2: proportional kick magnitude is `1 << KP_SHIFT` codes.
- LOCK_CNT, 8: number of alternating events required before lock is declared.

Ports:
- i_clk_gen  in  1  system clock, same domain as the PFD.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_up  in  1  PFD up pulse, one cycle wide.
- i_down  in  1  PFD down pulse, one cycle wide.
- i_hold  in  1  freezes the integrator and suppresses the proportional kick.
- o_ctrl  out  CTRL_W  registered DCO control code.
- o_sat_hi  out  1  registered; high while `o_ctrl` equals 2^CTRL_W-1.
- o_sat_lo  out  1  registered; high while `o_ctrl` equals 0.
- o_lock  out  1  registered lock indication.

## Operation
- **Error decode.**
  - err = +1 when `i_up` is high and `i_down` is low.
  - err = -1 when `i_down` is high and `i_up` is low.
  - err = 0 otherwise, including when both are high.
  - An "event" is any cycle with err ≠ 0.
- **Stage 1.** Register err into err_q (2-bit signed).
- **Stage 2, integrator update.**
  - integ += err_q unless any of the following hold:
    - `i_hold` is high;
    - err_q = +1 and `o_sat_hi` is high (anti-windup);
    - err_q = -1 and `o_sat_lo` is high (anti-windup);
    - the result would exceed the signed INT_W range. The integrator clamps and never wraps.
  - err_q is delayed into err_q2. err_q2 is forced to 0 when `i_hold` was high.
- **Stage 3, output.**
  - sum = INIT_CODE + (integ >>> FRAC_BITS) + err_q2·(1<<KP_SHIFT).
  - sum is computed signed at CTRL_W+INT_W+2 bits.
  - sum is clamped to [0, 2^CTRL_W-1] and registered into `o_ctrl`.
  - `o_sat_hi` and `o_sat_lo` are registered from the clamped value.
- The proportional kick is present in `o_ctrl` for exactly one cycle per event.
- **Reset, async, also mid-operation.** All state clears immediately:
  - `o_ctrl` = INIT_CODE;
  - integ = 0, err_q = 0, err_q2 = 0;
  - `o_sat_hi` = 0, `o_sat_lo` = 0;
  - `o_lock` = 0, lock counter = 0.
  - The first event after reset deassertion is processed normally.

## Timing
- An event sampled at edge N gives:
  - err_q at edge N+1;
  - integ and err_q2 at edge N+2;
  - `o_ctrl` at edge N+3.
- Latency from input to `o_ctrl` is 3 cycles. The integrator-only value follows on edge N+4 when no further event arrives.
- Back-to-back events, one per cycle, are all accepted. There is no stall and no handshake.
- Saturation flags are coincident with the `o_ctrl` value that caused them.
- The lock update uses err_q and is visible on `o_lock` at edge N+2.

## Configuration
- Macro `TT_LF_LOCK_DET_EN`.
- **Defined:** the lock detector is compiled in.
  - It keeps the previous nonzero err direction and a saturating counter sized for LOCK_CNT.
  - An event opposite to the previous direction increments the counter.
  - An event in the same direction clears the counter to 0.
  - `o_lock` is 1 while counter ≥ LOCK_CNT.
  - `o_lock` and the counter are cleared when `o_sat_hi` or `o_sat_lo` is high.
  - Events during `i_hold` are ignored by the lock detector.
- **Undefined:** no lock logic is synthesized and `o_lock` is tied to 0.

## Test plan
All scenarios use default parameters.
- **Reset:** assert `i_rst_n` low with random inputs -> `o_ctrl`=128, `o_sat_hi`=0, `o_sat_lo`=0, `o_lock`=0 immediately.
- **Single up pulse at edge 0:**
  - `o_ctrl`=132 at edge 3, then 128 at edge 4 (integ=1).
  - Three more up pulses, 4 cycles apart -> `o_ctrl` settles at 129.
- **Simultaneous events:** `i_up`=`i_down`=1 for 10 cycles -> `o_ctrl` stays 128 and integ stays 0. Pulses during `i_hold` produce no change.
- **Saturation:**
  - Continuous `i_up` -> `o_ctrl` reaches 255 and `o_sat_hi`=1; integ stops increasing.
  - One `i_down` -> `o_ctrl` drops to 251 for one cycle.
- **Lock (macro defined):**
  - Alternate up/down events, 8 total -> `o_lock`=1 two cycles after the 8th.
  - Two consecutive up events -> `o_lock`=0.
  - With the macro undefined -> `o_lock` stays 0.
- **Mid-run reset:** drive the integrator to 40, pulse `i_rst_n` low for one cycle -> `o_ctrl`=128, and the next up pulse gives 132 three cycles later.
